// File: rtl/bloom_pkg.sv
// Shared definitions for the counting Bloom filter.
//   op_t     : command encoding on op_code
//   state_t  : controller states (also visible on dbg_state)
//   SEED_BYTE: byte replicated across the key width to form the hash seed
//   bloom_idx: bucket index for hash function i of a key
package bloom_pkg;

    typedef enum logic [1:0] {
        OP_INS = 2'b00,
        OP_DEL = 2'b01,
        OP_QRY = 2'b10,
        OP_CLR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HASH  = 2'b01,
        ST_SWEEP = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    localparam logic [7:0] SEED_BYTE = 8'hA5;

    // Widest key the index function handles.
    localparam int MAX_D = 256;

    // idx_i = ((key ^ rotl(seed, i)) * (2i+1)) mod bl_size.
    // Rotation is within d_size bits. bl_size is a power of two, so the
    // modulo is a mask; callers keep only the low log2(bl_size) bits.
    function automatic logic [MAX_D-1:0] bloom_idx(
        input logic [MAX_D-1:0] key,
        input int               d_size,
        input int               bl_size,
        input int               i
    );
        logic [MAX_D-1:0] mask;
        logic [MAX_D-1:0] seed;
        logic [MAX_D-1:0] rot;
        logic [MAX_D-1:0] prod;
        mask = {MAX_D{1'b1}} >> (MAX_D - d_size);
        seed = '0;
        for (int k = 0; k < MAX_D / 8; k++) begin
            if (8 * k < d_size) begin
                seed = seed | (MAX_D'(SEED_BYTE) << (8 * k));
            end
        end
        seed = seed & mask;
        rot  = ((seed << i) | (seed >> (d_size - i))) & mask;
        prod = ((key & mask) ^ rot) * MAX_D'(2 * i + 1);
        return prod & MAX_D'(bl_size - 1);
    endfunction

endpackage

// File: rtl/bloom_hash_idx.sv
// Combinational bucket-index generator, time-shared across hash steps.
//   key  : latched key
//   step : hash function number i
//   idx  : bucket index for (key, i)
module bloom_hash_idx
    import bloom_pkg::*;
#(
    parameter int D_SIZE  = 8,
    parameter int BL_SIZE = 32,
    parameter int SW      = 2
) (
    input  logic [D_SIZE-1:0]          key,
    input  logic [SW-1:0]              step,
    output logic [$clog2(BL_SIZE)-1:0] idx
);

    localparam int IW = $clog2(BL_SIZE);

    logic [MAX_D-1:0] key_ext;

    always_comb begin
        key_ext              = '0;
        key_ext[D_SIZE-1:0]  = key;
        idx = IW'(bloom_idx(key_ext, D_SIZE, BL_SIZE, int'(step)));
    end

endmodule

// File: rtl/counting_bloom_filter.sv
// Counting Bloom filter: BL_SIZE saturating counters, NUM_HASH hash
// functions evaluated one bucket per cycle.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   op_valid/op_ready     : command handshake; transfer when both are high
//                           on a rising edge. op_ready is high only in IDLE.
//   op_code, data         : operation and key, sampled at transfer
//   resp_valid            : one-cycle pulse; match/underflow valid with it
//   sat_flag              : sticky, some counter reached all-ones
//   bl_out                : registered bucket-nonzero map
//   dbg_state             : current controller state
// Optional (BLOOM_STATS_EN defined): ins_count, occupancy.
module counting_bloom_filter
    import bloom_pkg::*;
#(
    parameter int D_SIZE   = 8,
    parameter int BL_SIZE  = 32,
    parameter int NUM_HASH = 3,
    parameter int CNT_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [1:0]                op_code,
    input  logic [D_SIZE-1:0]         data,
    output logic                      resp_valid,
    output logic                      match,
    output logic                      underflow,
    output logic                      sat_flag,
    output logic [BL_SIZE-1:0]        bl_out,
    output logic [1:0]                dbg_state
`ifdef BLOOM_STATS_EN
    ,
    output logic [15:0]               ins_count,
    output logic [$clog2(BL_SIZE):0]  occupancy
`endif
);

    localparam int IW = $clog2(BL_SIZE);
    localparam int SW = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
    localparam logic [CNT_W-1:0] CMAX       = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CMAX_M1    = CMAX - CNT_W'(1);
    localparam logic [SW-1:0]    STEP_LAST  = SW'(NUM_HASH - 1);
    localparam logic [IW-1:0]    SWEEP_LAST = IW'(BL_SIZE - 1);

    state_t            state, state_nx;
    logic              accept;
    logic [D_SIZE-1:0] key;
    op_t               opc;
    logic [SW-1:0]     step;
    logic [IW-1:0]     sweep;
    logic              pres;
    logic              unf;
    logic [CNT_W-1:0]  cnt [BL_SIZE];
    logic [IW-1:0]     idx;
    logic [CNT_W-1:0]  rd;
    logic              wr_en;
    logic [IW-1:0]     wr_addr;
    logic [CNT_W-1:0]  wr_data;
    logic              sat_set;

    assign dbg_state = state;

    bloom_hash_idx #(
        .D_SIZE  (D_SIZE),
        .BL_SIZE (BL_SIZE),
        .SW      (SW)
    ) u_hash (
        .key  (key),
        .step (step),
        .idx  (idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        op_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_nx = (op_code == OP_CLR) ? ST_SWEEP : ST_HASH;
                end
            end
            ST_HASH:  if (step == STEP_LAST)   state_nx = ST_RESP;
            ST_SWEEP: if (sweep == SWEEP_LAST) state_nx = ST_RESP;
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        accept = op_valid && op_ready;
    end

    // Single read port (rd) and single write port per cycle.
    always_comb begin
        rd      = cnt[idx];
        wr_en   = 1'b0;
        wr_addr = idx;
        wr_data = rd;
        sat_set = 1'b0;
        if (state == ST_HASH) begin
            case (opc)
                OP_INS: begin
                    if (rd != CMAX) begin
                        wr_en   = 1'b1;
                        wr_data = rd + CNT_W'(1);
                        sat_set = (rd == CMAX_M1);
                    end
                end
                OP_DEL: begin
                    // Saturated counters are frozen; zero ones flag underflow.
                    if (rd != '0 && rd != CMAX) begin
                        wr_en   = 1'b1;
                        wr_data = rd - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end else if (state == ST_SWEEP) begin
            wr_en   = 1'b1;
            wr_addr = sweep;
            wr_data = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key        <= '0;
            opc        <= OP_QRY;
            step       <= '0;
            sweep      <= '0;
            pres       <= 1'b0;
            unf        <= 1'b0;
            resp_valid <= 1'b0;
            match      <= 1'b0;
            underflow  <= 1'b0;
            sat_flag   <= 1'b0;
            bl_out     <= '0;
            for (int j = 0; j < BL_SIZE; j++) cnt[j] <= '0;
        end else begin
            // RESP is registered so the pulse lands NUM_HASH+1 edges after accept.
            resp_valid <= (state == ST_RESP);
            for (int j = 0; j < BL_SIZE; j++) bl_out[j] <= (cnt[j] != '0);
            if (wr_en)   cnt[wr_addr] <= wr_data;
            if (sat_set) sat_flag     <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        key   <= data;
                        opc   <= op_t'(op_code);
                        step  <= '0;
                        sweep <= '0;
                        pres  <= 1'b1;
                        unf   <= 1'b0;
                    end
                end
                ST_HASH: begin
                    step <= step + SW'(1);
                    pres <= pres & (rd != '0);
                    if (opc == OP_DEL && rd == '0) unf <= 1'b1;
                end
                ST_SWEEP: begin
                    sweep <= sweep + IW'(1);
                    if (sweep == SWEEP_LAST) sat_flag <= 1'b0;
                end
                ST_RESP: begin
                    match     <= pres & (opc != OP_CLR);
                    underflow <= unf & (opc != OP_CLR);
                end
                default: ;
            endcase
        end
    end

`ifdef BLOOM_STATS_EN
    logic [IW:0] pop;

    always_comb begin
        pop = '0;
        for (int j = 0; j < BL_SIZE; j++) pop = pop + {{IW{1'b0}}, bl_out[j]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ins_count <= '0;
            occupancy <= '0;
        end else begin
            if (state == ST_RESP && opc == OP_INS) ins_count <= ins_count + 16'd1;
            if (state == ST_RESP && opc == OP_CLR) ins_count <= '0;
            // bl_out lags the sweep, so hold occupancy at zero until it settles.
            if ((state == ST_SWEEP) || (state == ST_RESP && opc == OP_CLR))
                occupancy <= '0;
            else
                occupancy <= pop;
        end
    end
`endif

endmodule

// File: tb/tb_counting_bloom_filter.sv
module tb_counting_bloom_filter;

    localparam int D_SIZE   = 8;
    localparam int BL_SIZE  = 32;
    localparam int NUM_HASH = 3;
    localparam int CNT_W    = 4;
    localparam int CMAX     = (1 << CNT_W) - 1;

    localparam logic [1:0] C_INS = 2'b00;
    localparam logic [1:0] C_DEL = 2'b01;
    localparam logic [1:0] C_QRY = 2'b10;
    localparam logic [1:0] C_CLR = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic               op_valid = 1'b0;
    logic               op_ready;
    logic [1:0]         op_code = 2'b00;
    logic [D_SIZE-1:0]  data = '0;
    logic               resp_valid;
    logic               match;
    logic               underflow;
    logic               sat_flag;
    logic [BL_SIZE-1:0] bl_out;
    logic [1:0]         dbg_state;
`ifdef BLOOM_STATS_EN
    logic [15:0]              ins_count;
    logic [$clog2(BL_SIZE):0] occupancy;
`endif

    counting_bloom_filter #(
        .D_SIZE   (D_SIZE),
        .BL_SIZE  (BL_SIZE),
        .NUM_HASH (NUM_HASH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .data       (data),
        .resp_valid (resp_valid),
        .match      (match),
        .underflow  (underflow),
        .sat_flag   (sat_flag),
        .bl_out     (bl_out),
        .dbg_state  (dbg_state)
`ifdef BLOOM_STATS_EN
        ,
        .ins_count  (ins_count),
        .occupancy  (occupancy)
`endif
    );

    // ---------------- reference model ----------------
    int mcnt [BL_SIZE];
    bit msat;

    typedef struct {
        logic               m;
        logic               u;
        logic [BL_SIZE-1:0] bl;
        logic               sat;
        int                 acc;
        int                 lat;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int m_idx(input logic [7:0] k, input int i);
        logic [7:0] s;
        logic [7:0] r;
        int p;
        s = 8'hA5;
        r = (s << i) | (s >> (8 - i));
        p = int'(k ^ r) * (2 * i + 1);
        return p % BL_SIZE;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < BL_SIZE; j++) mcnt[j] = 0;
        msat = 1'b0;
    endtask

    task automatic model_apply(input logic [1:0] op, input logic [7:0] k, output exp_t e);
        bit pres;
        bit unf;
        int ix;
        int v;
        pres = 1'b1;
        unf  = 1'b0;
        if (op == C_CLR) begin
            model_reset();
            pres  = 1'b0;
            e.lat = BL_SIZE + 1;
        end else begin
            for (int i = 0; i < NUM_HASH; i++) begin
                ix = m_idx(k, i);
                v  = mcnt[ix];
                if (v == 0) pres = 1'b0;
                if (op == C_INS && v < CMAX) begin
                    mcnt[ix] = v + 1;
                    if (v + 1 == CMAX) msat = 1'b1;
                end
                if (op == C_DEL) begin
                    if (v == 0) unf = 1'b1;
                    else if (v < CMAX) mcnt[ix] = v - 1;
                end
            end
            e.lat = NUM_HASH + 1;
        end
        e.m   = pres;
        e.u   = unf;
        e.sat = msat;
        for (int j = 0; j < BL_SIZE; j++) e.bl[j] = (mcnt[j] != 0);
    endtask

    // ---------------- driver ----------------
    task automatic do_op(input logic [1:0] op, input logic [7:0] k, input bit expect_resp);
        exp_t e;
        int w;
        w = 0;
        @(negedge clk);
        while (!op_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!op_ready) begin
            check("ready_timeout", 64'(op_ready), 64'd1);
            return;
        end
        op_valid = 1'b1;
        op_code  = op;
        data     = k;
        if (expect_resp) begin
            model_apply(op, k, e);
            e.acc = cyc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        check("busy_ready", 64'(op_ready), 64'd0);
        // Junk while busy must be ignored.
        op_code = 2'($urandom_range(0, 3));
        data    = 8'($urandom);
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && resp_valid) begin
                check("resp_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("match", 64'(match), 64'(e.m));
                    check("underflow", 64'(underflow), 64'(e.u));
                    check("bl_out", 64'(bl_out), 64'(e.bl));
                    check("sat_flag", 64'(sat_flag), 64'(e.sat));
                    check("latency", 64'(cyc - e.acc - 1), 64'(e.lat));
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] k;
        int r;
        model_reset();
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_op_ready", 64'(op_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_match", 64'(match), 64'd0);
        check("rst_underflow", 64'(underflow), 64'd0);
        check("rst_sat_flag", 64'(sat_flag), 64'd0);
        check("rst_bl_out", 64'(bl_out), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);

        // Query on empty, insert, query again.
        do_op(C_QRY, 8'h00, 1'b1);
        wait_drain();
        do_op(C_INS, 8'h00, 1'b1);
        wait_drain();
        check("bl_ins00_buckets", 64'(bl_out), 64'h4022);
        do_op(C_QRY, 8'h00, 1'b1);
        wait_drain();

        // Double insert, delete, delete.
        do_op(C_CLR, 8'h00, 1'b1);
        do_op(C_INS, 8'h00, 1'b1);
        do_op(C_INS, 8'h00, 1'b1);
        do_op(C_DEL, 8'h00, 1'b1);
        do_op(C_QRY, 8'h00, 1'b1);
        do_op(C_DEL, 8'h00, 1'b1);
        do_op(C_QRY, 8'h00, 1'b1);
        // Underflow on empty filter.
        do_op(C_DEL, 8'h00, 1'b1);
        wait_drain();
        check("bl_after_underflow", 64'(bl_out), 64'd0);

        // Saturation, then deletes must not move saturated buckets.
        for (int n = 0; n < 16; n++) do_op(C_INS, 8'h00, 1'b1);
        wait_drain();
        check("sat_after_16ins", 64'(sat_flag), 64'd1);
        for (int n = 0; n < 16; n++) do_op(C_DEL, 8'h00, 1'b1);
        do_op(C_QRY, 8'h00, 1'b1);
        wait_drain();
        check("bl_sat_frozen", 64'(bl_out), 64'h4022);
        do_op(C_CLR, 8'h00, 1'b1);
        wait_drain();

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            k = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            if (r < 40)      do_op(C_INS, k, 1'b1);
            else if (r < 65) do_op(C_DEL, k, 1'b1);
            else if (r < 97) do_op(C_QRY, k, 1'b1);
            else             do_op(C_CLR, k, 1'b1);
        end

        // Clear after inserts.
        do_op(C_INS, 8'h3C, 1'b1);
        do_op(C_INS, 8'h00, 1'b1);
        do_op(C_CLR, 8'h00, 1'b1);
        wait_drain();
        check("bl_after_clear", 64'(bl_out), 64'd0);

        // Reset in the middle of HASH aborts the op.
        do_op(C_INS, 8'h5A, 1'b0);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst_bl_out", 64'(bl_out), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_op_ready", 64'(op_ready), 64'd1);
        check("midrst_state", 64'(dbg_state), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid), 64'd0);
        repeat (8) @(negedge clk);
        do_op(C_QRY, 8'h5A, 1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
